// File: rtl/dmem_dbg_pkg.sv
// dmem_dbg_pkg: shared state encoding, constants and byte picker for the data-memory dump
package dmem_dbg_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int MEM_AW = 10;
  typedef enum logic [2:0] {IDLE, ARM, READ, SEND, FIN} state_t;
  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx, input logic msb_first);
    logic [1:0] k;
    k = msb_first ? ~idx : idx;
    return word[8*k +: 8];
  endfunction
endpackage

// File: rtl/dump_byte_serializer.sv
// dump_byte_serializer: holds one captured word and streams it as 4 bytes over valid/ready
module dump_byte_serializer
  import dmem_dbg_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [31:0] i_word,
  input  logic        i_abort,
  input  logic        i_ready,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  output logic        o_acc,
  output logic        o_last_acc
);
  logic [31:0] r_word;
  logic [1:0]  r_idx;
  logic        r_valid;
  logic [7:0]  r_data;
  assign o_tx_valid = r_valid;
  assign o_tx_data  = r_data;
  assign o_acc      = r_valid & i_ready;
  assign o_last_acc = o_acc & (r_idx == 2'(BYTES_PER_WORD - 1));
  // load a fresh word, then step through its bytes one handshake at a time; abort drops valid after the current byte
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_word  <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_word  <= i_word;
      r_idx   <= '0;
      r_valid <= 1'b1;
      r_data  <= byte_sel(i_word, 2'd0, MSB_FIRST);
    end else if (o_acc) begin
      r_idx   <= r_idx + 2'd1;
      r_valid <= !(o_last_acc || i_abort);
      r_data  <= byte_sel(r_word, r_idx + 2'd1, MSB_FIRST);
    end
endmodule

// File: rtl/dmem_dump_ctrl.sv
// dmem_dump_ctrl: walks the data memory in debug mode and streams every word to the UART
module dmem_dump_ctrl
  import dmem_dbg_pkg::*;
#(
  parameter int ADDR_B    = 32,
  parameter int WIDTH_B   = 32,
  parameter int DEPTH     = 1024,
  parameter int RD_LAT    = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              debug_mode,
  output logic [ADDR_B-1:0] debug_addr,
  input  logic [WIDTH_B-1:0] mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);
  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);
  localparam logic [MEM_AW-1:0] ADDR_LAST = MEM_AW'(DEPTH - 1);
  state_t            r_state;
  logic [MEM_AW-1:0] r_addr;
  logic [1:0]        r_lat;
  logic              r_mode;
  logic              r_busy;
  logic              r_done;
  logic              w_load;
  logic              w_acc;
  logic              w_last;
  assign debug_mode = r_mode;
  assign debug_addr = {{(ADDR_B - MEM_AW){1'b0}}, r_addr};
  assign busy       = r_busy;
  assign done       = r_done;
  assign w_load     = (r_state == READ) && (r_lat == LAT_LAST) && !abort;
  dump_byte_serializer #(.MSB_FIRST(MSB_FIRST != 0)) u_ser (
    .clk       (clk),
    .rst       (reset),
    .i_load    (w_load),
    .i_word    (mem_rdata),
    .i_abort   (abort),
    .i_ready   (tx_ready),
    .o_tx_valid(tx_valid),
    .o_tx_data (tx_data),
    .o_acc     (w_acc),
    .o_last_acc(w_last)
  );
  // dump sequencer: guard cycle, read wait, byte streaming, and a one-cycle finish with done
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_lat   <= '0;
      r_mode  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state <= ARM;
          r_mode  <= 1'b1;
          r_busy  <= 1'b1;
          r_addr  <= '0;
        end
        ARM: begin
          r_state <= READ;
          r_lat   <= '0;
        end
        READ: if (abort) begin
          r_state <= FIN;
          r_done  <= 1'b1;
        end else if (r_lat == LAT_LAST) begin
          r_state <= SEND;
          r_lat   <= '0;
        end else r_lat <= r_lat + 2'd1;
        SEND: if (w_acc && (abort || w_last)) begin
          if (abort || r_addr == ADDR_LAST) begin
            r_state <= FIN;
            r_done  <= 1'b1;
          end else begin
            r_state <= READ;
            r_addr  <= r_addr + MEM_AW'(1);
          end
        end
        FIN: begin
          r_state <= IDLE;
          r_mode  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// tb_dmem_dump_ctrl: self-checking bench for the data-memory dump controller
module tb_dmem_dump_ctrl;
  localparam int DEPTH = 4;
  typedef struct {
    int period;
    int abort_at;
    int restart_at;
    int rnd_mem;
    int exp_bytes;
    int exp_cycles;
  } vec_t;
  logic clk = 1'b0;
  logic reset, start, abort, tx_ready;
  logic mode_m, mode_l, valid_m, valid_l, busy_m, busy_l, done_m, done_l;
  logic [31:0] addr_m, addr_l, rdata_m, rdata_l;
  logic [7:0] data_m, data_l;
  logic [31:0] mem [DEPTH];
  int errs = 0;
  int chks = 0;
  always #5 clk = ~clk;
  assign rdata_m = mem[addr_m[1:0]];
  assign rdata_l = mem[addr_l[1:0]];
  dmem_dump_ctrl #(.DEPTH(DEPTH), .RD_LAT(1), .MSB_FIRST(1)) dut_m (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .debug_mode(mode_m), .debug_addr(addr_m), .mem_rdata(rdata_m),
    .tx_data(data_m), .tx_valid(valid_m), .tx_ready(tx_ready),
    .busy(busy_m), .done(done_m)
  );
  dmem_dump_ctrl #(.DEPTH(DEPTH), .RD_LAT(1), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .debug_mode(mode_l), .debug_addr(addr_l), .mem_rdata(rdata_l),
    .tx_data(data_l), .tx_valid(valid_l), .tx_ready(tx_ready),
    .busy(busy_l), .done(done_l)
  );
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  function automatic logic [7:0] exp_byte(input int k, input bit msb);
    logic [31:0] w;
    int p;
    w = mem[k / 4];
    p = msb ? 3 - (k % 4) : k % 4;
    return w[8*p +: 8];
  endfunction
  task automatic check_zero(input string nm);
    chk({nm, "_mode"}, {31'd0, mode_m | mode_l}, 0);
    chk({nm, "_addr"}, addr_m | addr_l, 0);
    chk({nm, "_valid"}, {31'd0, valid_m | valid_l}, 0);
    chk({nm, "_data"}, {24'd0, data_m | data_l}, 0);
    chk({nm, "_busy"}, {31'd0, busy_m | busy_l}, 0);
    chk({nm, "_done"}, {31'd0, done_m | done_l}, 0);
  endtask
  task automatic run(input vec_t v);
    int nb, ndone, cyc, post, dc;
    bit held, pv, pr, restarted;
    logic [7:0] pd;
    logic [31:0] pa;
    nb = 0; ndone = 0; cyc = 0; post = -1; dc = -1;
    held = 0; pv = 0; pr = 0; restarted = 0; pd = '0; pa = '0;
    if (v.rnd_mem != 0) foreach (mem[i]) mem[i] = $urandom;
    else mem = '{32'h11223344, 32'hAABBCCDD, 32'h00000000, 32'hDEADBEEF};
    @(posedge clk); #1;
    start = 1'b1;
    while (cyc < 400 && post < 3) begin
      if (v.abort_at == -2 && cyc == 0) held = 1;
      if (v.abort_at >= 0 && nb == v.abort_at && valid_m) held = 1;
      abort = held;
      tx_ready = (v.period == 0) ? 1'($urandom_range(0, 1)) : (cyc % v.period == 0);
      @(negedge clk);
      if (pv && !pr) begin
        chk("hold_valid", {31'd0, valid_m}, 1);
        chk("hold_data", {24'd0, data_m}, {24'd0, pd});
        chk("hold_addr", addr_m, pa);
      end
      if (valid_m && tx_ready) begin
        if (nb < 4 * DEPTH) begin
          chk("byte_msb", {24'd0, data_m}, {24'd0, exp_byte(nb, 1)});
          chk("byte_lsb_valid", {31'd0, valid_l}, 1);
          chk("byte_lsb", {24'd0, data_l}, {24'd0, exp_byte(nb, 0)});
          chk("word_addr", addr_m, nb / 4);
          chk("send_mode", {31'd0, mode_m}, 1);
        end
        nb++;
      end
      if (post >= 0) begin
        chk("post_mode", {31'd0, mode_m}, 0);
        chk("post_busy", {31'd0, busy_m}, 0);
        chk("post_done", {31'd0, done_m}, 0);
        post++;
      end else if (done_m) begin
        ndone++;
        dc = cyc;
        chk("done_busy", {31'd0, busy_m}, 1);
        chk("done_mode", {31'd0, mode_m}, 1);
        post = 0;
        held = 0;
      end
      pv = valid_m; pr = tx_ready; pd = data_m; pa = addr_m;
      @(posedge clk); #1;
      start = (v.restart_at >= 0 && nb == v.restart_at && !restarted);
      if (start) restarted = 1;
      cyc++;
    end
    abort = 1'b0;
    start = 1'b0;
    if (post < 3) begin
      chks++;
      errs++;
      $display("FAIL timeout: got no completed dump in %0d cycles expected done", cyc);
    end else begin
      chk("n_bytes", nb, v.exp_bytes);
      chk("n_done", ndone, 1);
      if (v.exp_cycles > 0) chk("done_cycle", dc, v.exp_cycles);
    end
  endtask
  initial begin
    vec_t vecs[9];
    int w;
    vecs[0] = '{1, -1, -1, 0, 16, 22};
    vecs[1] = '{3, -1, -1, 0, 16, 0};
    vecs[2] = '{1, 6, -1, 0, 7, 11};
    vecs[3] = '{3, 6, -1, 0, 7, 0};
    vecs[4] = '{1, -2, -1, 0, 0, 3};
    vecs[5] = '{1, -1, 8, 0, 16, 22};
    vecs[6] = '{0, -1, -1, 1, 16, 0};
    vecs[7] = '{0, 13, -1, 1, 14, 0};
    vecs[8] = '{1, -1, -1, 1, 16, 22};
    mem = '{32'h11223344, 32'hAABBCCDD, 32'h00000000, 32'hDEADBEEF};
    reset = 1'b1; start = 1'b0; abort = 1'b0; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 9; i++) run(vecs[i]);
    mem = '{32'h11223344, 32'hAABBCCDD, 32'h00000000, 32'hDEADBEEF};
    @(posedge clk); #1;
    start = 1'b1; tx_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (!valid_m && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("rst_reach_send", {31'd0, valid_m}, 1);
    #2 reset = 1'b1;
    #1;
    check_zero("async_rst");
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_done", {31'd0, done_m}, 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    run(vecs[0]);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
